pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: width of every address port and stack entry.
REQ-002 Parameter RESET_ADDR, default 0: PC value loaded by reset.
REQ-003 Parameter STEP, default 1: sequential increment, in address units.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, >= 2.
REQ-005 clock  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pc_write  input  1  1 = PC may advance; 0 = stall (hold).
REQ-008 redirect_valid  input  1  branch/jump resolved; load redirect_addr.
REQ-009 redirect_addr  input  ADDR_WIDTH  redirect target.
REQ-010 call  input  1  current instruction is a call; push return address.
REQ-011 ret  input  1  current instruction is a return; pop predicted target.
REQ-012 pc_current  output  ADDR_WIDTH  registered PC, to instruction memory.
REQ-013 pc_plus  output  ADDR_WIDTH  combinational (pc_current + STEP) mod 2^ADDR_WIDTH.
REQ-014 ras_count  output  clog2(RAS_DEPTH)+1  number of valid stack entries.
REQ-015 ras_empty  output  1  ras_count == 0.
REQ-016 ras_full  output  1  ras_count == RAS_DEPTH.
REQ-017 ras_underflow  output  1  registered one-cycle pulse: ret accepted with an empty stack.

Function
REQ-018 The next PC is chosen by fixed priority, highest first: reset > redirect_valid > !pc_write > ret > call > sequential.
REQ-019 redirect_valid=1 loads redirect_addr regardless of pc_write; call and ret are ignored that cycle and the stack is unchanged.
REQ-020 When pc_write=0 and redirect_valid=0, pc_current, the stack and ras_count hold, and call/ret are ignored.
REQ-021 Sequential: pc_current <= pc_plus; the addition wraps modulo 2^ADDR_WIDTH with no flag.
REQ-022 ret accepted with stack non-empty: pc_current <= top entry, ras_count decrements, 1-cycle latency.
REQ-023 ret accepted with stack empty: pc_current <= pc_plus, ras_count stays 0, and ras_underflow pulses high on the next cycle.
REQ-024 call accepted (ret=0): push pc_plus, pc_current <= pc_plus, ras_count increments.
REQ-025 call accepted with ras_full: the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, and the push still succeeds.
REQ-026 call and ret accepted together, stack non-empty: pc_current <= top entry, the top is replaced by pc_plus, ras_count unchanged.
REQ-027 call and ret accepted together, stack empty: behaves as call alone, and ras_underflow pulses.
REQ-028 The stack is a circular buffer with a top pointer that wraps modulo RAS_DEPTH; entries are not cleared on pop.
REQ-029 pc_plus, ras_empty and ras_full are purely combinational from registered state; all other outputs are registered.

Reset
REQ-030 reset=1 at a rising edge sets pc_current=RESET_ADDR, ras_count=0, top pointer=0 and ras_underflow=0, overriding every other input.
REQ-031 Reset asserted in the middle of a call/ret sequence discards all stack contents; stack entry storage need not be cleared.
REQ-032 After reset deasserts, the first PC advance happens on the first edge with pc_write=1.

Verification
REQ-033 Reset, then pc_write=1 for 3 cycles (STEP=1) -> pc_current 0,1,2,3; ras_empty=1.
REQ-034 pc_current=0x3FF, pc_write=1 (ADDR_WIDTH=10) -> pc_current=0x000 next cycle.
REQ-035 At pc=0x010, call, then redirect to 0x100, then ret -> pc_current 0x011, 0x100, 0x011; ras_count 1, 1, 0.
REQ-036 Five calls with RAS_DEPTH=4 at pcs 0x20,0x40,0x60,0x80,0xA0 (redirects between them) -> ras_count=4; four rets return 0xA1, 0x81, 0x61, 0x41; a fifth ret gives pc_plus and ras_underflow=1 for exactly one cycle.
REQ-037 pc_write=0 with call=1 and ret=1 for 2 cycles -> pc_current and ras_count unchanged; redirect_valid=1 with pc_write=0 -> pc_current=redirect_addr.
REQ-038 Simultaneous call+ret with top=0x050 at pc=0x030 -> pc_current=0x050, new top=0x031, ras_count unchanged; reset during this sequence -> pc_current=RESET_ADDR, ras_count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer with a fixed-priority next-PC
//                select (reset > redirect > stall > ret > call > sequential)
//                and a circular return-address stack for call/return
//                prediction.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESET_ADDR = 0,
  parameter int STEP       = 1,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pc_write,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_addr,
  input  logic                          call,
  input  logic                          ret,
  output logic [ADDR_WIDTH-1:0]         pc_current,
  output logic [ADDR_WIDTH-1:0]         pc_plus,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_empty,
  output logic                          ras_full,
  output logic                          ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] C_RESET_PC = ADDR_WIDTH'(RESET_ADDR);
  localparam logic [ADDR_WIDTH-1:0] C_STEP     = ADDR_WIDTH'(STEP);
  localparam logic [CNT_W-1:0]      C_FULL_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]      C_PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]      C_CNT_ONE  = CNT_W'(1);

  // Architectural state
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]      top_q, top_d;      // next free slot; top entry is top_q-1
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic [ADDR_WIDTH-1:0] stack_q [RAS_DEPTH];

  // Stack write port
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_idx;
  logic [ADDR_WIDTH-1:0] wr_data;

  // Helpers derived from registered state
  logic [ADDR_WIDTH-1:0] pc_plus_w;
  logic [PTR_W-1:0]      top_m1_w;
  logic                  empty_w;
  logic                  full_w;

  assign pc_plus_w = pc_q + C_STEP;          // wraps naturally at ADDR_WIDTH bits
  assign top_m1_w  = top_q - C_PTR_ONE;      // index of the most recent entry
  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == C_FULL_CNT);

  assign pc_current    = pc_q;
  assign pc_plus       = pc_plus_w;
  assign ras_count     = count_q;
  assign ras_empty     = empty_w;
  assign ras_full      = full_w;
  assign ras_underflow = underflow_q;

  // Next-state selection: fixed priority redirect > stall > ret > call > sequential
  always_comb begin
    pc_d        = pc_q;
    top_d       = top_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = top_q;
    wr_data     = pc_plus_w;

    if (redirect_valid) begin
      // Resolved branch wins over everything; the stack is left untouched.
      pc_d = redirect_addr;
    end else if (!pc_write) begin
      // Stall: hold PC and stack, ignore call/ret.
      pc_d = pc_q;
    end else if (ret) begin
      if (!empty_w) begin
        pc_d = stack_q[top_m1_w];
        if (call) begin
          // Pop and push in the same cycle collapse to replacing the top.
          wr_en  = 1'b1;
          wr_idx = top_m1_w;
        end else begin
          top_d   = top_m1_w;
          count_d = count_q - C_CNT_ONE;
        end
      end else begin
        // Return with nothing predicted: fall through and flag it.
        underflow_d = 1'b1;
        pc_d        = pc_plus_w;
        if (call) begin
          wr_en   = 1'b1;
          wr_idx  = top_q;
          top_d   = top_q + C_PTR_ONE;
          count_d = count_q + C_CNT_ONE;
        end
      end
    end else if (call) begin
      // Push; when full the slot at top_q is the oldest entry, so it is
      // overwritten and the count saturates.
      pc_d    = pc_plus_w;
      wr_en   = 1'b1;
      wr_idx  = top_q;
      top_d   = top_q + C_PTR_ONE;
      if (!full_w) begin
        count_d = count_q + C_CNT_ONE;
      end
    end else begin
      pc_d = pc_plus_w;
    end
  end

  // PC, stack pointer, occupancy and underflow pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= C_RESET_PC;
      top_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      top_q       <= top_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack entry storage; contents are invalidated by the count, never cleared
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      stack_q[wr_idx] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed-vector bench for pc_sequencer with a queue-based
//                scoreboard and an independent monitor process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pc_write = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [9:0] redirect_addr = '0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [9:0] pc_current;
  logic [9:0] pc_plus;
  logic [2:0] ras_count;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_underflow;

  pc_sequencer #(
    .ADDR_WIDTH (10),
    .RESET_ADDR (0),
    .STEP       (1),
    .RAS_DEPTH  (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .call           (call),
    .ret            (ret),
    .pc_current     (pc_current),
    .pc_plus        (pc_plus),
    .ras_count      (ras_count),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ras_underflow  (ras_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [9:0] pc;
    logic [2:0] cnt;
    logic       uf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Drive one cycle of inputs at the falling edge and queue the state
  // expected right after the following rising edge.
  task automatic apply(input string nm, input logic r, input logic pw,
                       input logic rv, input logic [9:0] ra,
                       input logic c, input logic rt,
                       input logic [9:0] epc, input logic [2:0] ecnt,
                       input logic euf);
    exp_t e;
    @(negedge clock);
    reset          = r;
    pc_write       = pw;
    redirect_valid = rv;
    redirect_addr  = ra;
    call           = c;
    ret            = rt;
    e.name = nm;
    e.pc   = epc;
    e.cnt  = ecnt;
    e.uf   = euf;
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare the DUT state with the oldest
  // outstanding expectation.
  initial begin
    exp_t       e;
    logic [9:0] exp_plus;
    logic       exp_empty;
    logic       exp_full;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e         = exp_q.pop_front();
        exp_plus  = e.pc + 10'd1;
        exp_empty = (e.cnt == 3'd0);
        exp_full  = (e.cnt == 3'd4);
        n_checks++;
        if (pc_current === e.pc && pc_plus === exp_plus &&
            ras_count === e.cnt && ras_empty === exp_empty &&
            ras_full === exp_full && ras_underflow === e.uf) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got pc=%h plus=%h cnt=%0d empty=%b full=%b uf=%b, want pc=%h plus=%h cnt=%0d empty=%b full=%b uf=%b",
                   e.name, pc_current, pc_plus, ras_count, ras_empty, ras_full, ras_underflow,
                   e.pc, exp_plus, e.cnt, exp_empty, exp_full, e.uf);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  // Stimulus:    name        rst pw rv addr    call ret  pc      cnt  uf
  initial begin
    apply("reset",        1, 0, 0, 10'h000, 0, 0, 10'h000, 3'd0, 0);
    apply("hold_pw0",     0, 0, 0, 10'h000, 0, 0, 10'h000, 3'd0, 0);
    apply("seq1",         0, 1, 0, 10'h000, 0, 0, 10'h001, 3'd0, 0);
    apply("seq2",         0, 1, 0, 10'h000, 0, 0, 10'h002, 3'd0, 0);
    apply("seq3",         0, 1, 0, 10'h000, 0, 0, 10'h003, 3'd0, 0);
    // Wrap at the top of the address space
    apply("redir_3ff",    0, 1, 1, 10'h3FF, 0, 0, 10'h3FF, 3'd0, 0);
    apply("wrap",         0, 1, 0, 10'h000, 0, 0, 10'h000, 3'd0, 0);
    // call / redirect / ret
    apply("redir_010",    0, 1, 1, 10'h010, 0, 0, 10'h010, 3'd0, 0);
    apply("call_010",     0, 1, 0, 10'h000, 1, 0, 10'h011, 3'd1, 0);
    apply("redir_100",    0, 1, 1, 10'h100, 0, 1, 10'h100, 3'd1, 0);
    apply("ret_011",      0, 1, 0, 10'h000, 0, 1, 10'h011, 3'd0, 0);
    // Five calls into a depth-4 stack
    apply("redir_020",    0, 1, 1, 10'h020, 0, 0, 10'h020, 3'd0, 0);
    apply("call_020",     0, 1, 0, 10'h000, 1, 0, 10'h021, 3'd1, 0);
    apply("redir_040",    0, 1, 1, 10'h040, 1, 0, 10'h040, 3'd1, 0);
    apply("call_040",     0, 1, 0, 10'h000, 1, 0, 10'h041, 3'd2, 0);
    apply("redir_060",    0, 1, 1, 10'h060, 0, 0, 10'h060, 3'd2, 0);
    apply("call_060",     0, 1, 0, 10'h000, 1, 0, 10'h061, 3'd3, 0);
    apply("redir_080",    0, 1, 1, 10'h080, 0, 0, 10'h080, 3'd3, 0);
    apply("call_080",     0, 1, 0, 10'h000, 1, 0, 10'h081, 3'd4, 0);
    apply("redir_0a0",    0, 1, 1, 10'h0A0, 0, 0, 10'h0A0, 3'd4, 0);
    apply("call_full",    0, 1, 0, 10'h000, 1, 0, 10'h0A1, 3'd4, 0);
    apply("ret_0a1",      0, 1, 0, 10'h000, 0, 1, 10'h0A1, 3'd3, 0);
    apply("ret_081",      0, 1, 0, 10'h000, 0, 1, 10'h081, 3'd2, 0);
    apply("ret_061",      0, 1, 0, 10'h000, 0, 1, 10'h061, 3'd1, 0);
    apply("ret_041",      0, 1, 0, 10'h000, 0, 1, 10'h041, 3'd0, 0);
    apply("ret_underflow",0, 1, 0, 10'h000, 0, 1, 10'h042, 3'd0, 1);
    apply("uf_clears",    0, 1, 0, 10'h000, 0, 0, 10'h043, 3'd0, 0);
    // Stall ignores call/ret; redirect overrides stall
    apply("call_043",     0, 1, 0, 10'h000, 1, 0, 10'h044, 3'd1, 0);
    apply("stall_cr1",    0, 0, 0, 10'h000, 1, 1, 10'h044, 3'd1, 0);
    apply("stall_cr2",    0, 0, 0, 10'h000, 1, 1, 10'h044, 3'd1, 0);
    apply("stall_redir",  0, 0, 1, 10'h200, 0, 0, 10'h200, 3'd1, 0);
    // Simultaneous call+ret replaces the top
    apply("redir_04f",    0, 1, 1, 10'h04F, 0, 0, 10'h04F, 3'd1, 0);
    apply("call_04f",     0, 1, 0, 10'h000, 1, 0, 10'h050, 3'd2, 0);
    apply("redir_030",    0, 1, 1, 10'h030, 0, 0, 10'h030, 3'd2, 0);
    apply("callret_030",  0, 1, 0, 10'h000, 1, 1, 10'h050, 3'd2, 0);
    apply("ret_new_top",  0, 1, 0, 10'h000, 0, 1, 10'h031, 3'd1, 0);
    apply("ret_044",      0, 1, 0, 10'h000, 0, 1, 10'h044, 3'd0, 0);
    // Reset mid-sequence discards the stack
    apply("call_044",     0, 1, 0, 10'h000, 1, 0, 10'h045, 3'd1, 0);
    apply("reset_mid",    1, 1, 1, 10'h123, 1, 1, 10'h000, 3'd0, 0);
    apply("ret_after_rst",0, 1, 0, 10'h000, 0, 1, 10'h001, 3'd0, 1);
    // call+ret on an empty stack behaves as call and still flags underflow
    apply("callret_empty",0, 1, 0, 10'h000, 1, 1, 10'h002, 3'd1, 1);
    apply("ret_002",      0, 1, 0, 10'h000, 0, 1, 10'h002, 3'd0, 0);

    @(negedge clock);
    reset          = 1'b0;
    pc_write       = 1'b0;
    redirect_valid = 1'b0;
    call           = 1'b0;
    ret            = 1'b0;
    repeat (3) @(negedge clock);

    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
